// File: rtl/cache_pkg.sv
// cache_pkg: sizes, state and selector types shared
// by the cache miss fill controller and its counter.
package cache_pkg;

  localparam int ADDR_W     = 16;
  localparam int BLK_WORDS  = 8;
  localparam int WORD_IDX_W = 3;
  localparam int MEM_LAT    = 4;
  localparam int CNT_W      = WORD_IDX_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  typedef enum logic {
    SEL_I = 1'b0,
    SEL_D = 1'b1
  } req_sel_t;

  // Block base: clear the byte-within-block bits.
  function automatic logic [ADDR_W-1:0] blk_base(
    input logic [ADDR_W-1:0] a
  );
    blk_base = a & ~ADDR_W'(2 * BLK_WORDS - 1);
  endfunction

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// cache_fill_ctrl_if: miss, memory and fill bundle.
// master = fill controller, slave = caches + memory.
interface cache_fill_ctrl_if;
  import cache_pkg::*;

  logic              i_miss;
  logic [ADDR_W-1:0] i_miss_addr;
  logic              d_miss;
  logic [ADDR_W-1:0] d_miss_addr;
  logic              i_busy;
  logic              d_busy;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic              mem_rvalid;
  logic              fill_sel;
  logic              fill_we;
  logic [WORD_IDX_W-1:0] fill_word;
  logic [15:0]       fill_data;
  logic [ADDR_W-1:0] fill_addr;
  logic              tag_we;

  modport master (
    input  i_miss, i_miss_addr,
    input  d_miss, d_miss_addr,
    input  mem_rdata, mem_rvalid,
    output i_busy, d_busy,
    output mem_en, mem_addr,
    output fill_sel, fill_we, fill_word,
    output fill_data, fill_addr, tag_we
  );

  modport slave (
    output i_miss, i_miss_addr,
    output d_miss, d_miss_addr,
    output mem_rdata, mem_rvalid,
    input  i_busy, d_busy,
    input  mem_en, mem_addr,
    input  fill_sel, fill_we, fill_word,
    input  fill_data, fill_addr, tag_we
  );

endinterface

// File: rtl/blk_word_cnt.sv
// blk_word_cnt: word counter for one block, clear has
// priority, saturates at BLK_WORDS with done_o high.
// Ports: clk, rst, clr_i, en_i -> idx_o, done_o.
module blk_word_cnt
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  en_i,
  output logic [WORD_IDX_W-1:0] idx_o,
  output logic                  done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !done_o)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign idx_o  = cnt_q[WORD_IDX_W-1:0];
  assign done_o = (cnt_q == CNT_W'(BLK_WORDS));

endmodule

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: arbitrates I/D misses (D first),
// issues 8 pipelined word reads and streams them in.
// Ports: clk, rst (sync, active-high), bus (master).
module cache_fill_ctrl
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  cache_fill_ctrl_if.master bus
);

  fill_state_t       state_q, state_d;
  req_sel_t          sel_q, sel_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic                  cnt_clr;
  logic                  iss_en;
  logic                  rcv_en;
  logic                  iss_done;
  logic                  rcv_done;
  logic [WORD_IDX_W-1:0] iss_idx;
  logic [WORD_IDX_W-1:0] rcv_idx;
  logic                  tag_we;

  blk_word_cnt u_iss (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .en_i   (iss_en),
    .idx_o  (iss_idx),
    .done_o (iss_done)
  );

  blk_word_cnt u_rcv (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .en_i   (rcv_en),
    .idx_o  (rcv_idx),
    .done_o (rcv_done)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    base_d  = base_q;
    cnt_clr = 1'b0;
    iss_en  = 1'b0;
    rcv_en  = 1'b0;
    tag_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // D has priority over I on a tie.
        if (bus.d_miss) begin
          sel_d   = SEL_D;
          base_d  = blk_base(bus.d_miss_addr);
          cnt_clr = 1'b1;
          state_d = FILL;
        end else if (bus.i_miss) begin
          sel_d   = SEL_I;
          base_d  = blk_base(bus.i_miss_addr);
          cnt_clr = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        iss_en = !iss_done;
        rcv_en = bus.mem_rvalid && !rcv_done;
        // Last word: tag write and leave FILL.
        if (rcv_en &&
            rcv_idx == WORD_IDX_W'(BLK_WORDS - 1)) begin
          tag_we  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= SEL_I;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      base_q  <= base_d;
    end
  end

  assign bus.mem_en   = iss_en;
  assign bus.mem_addr = {
    base_q[ADDR_W-1:WORD_IDX_W+1], iss_idx, 1'b0
  };

  assign bus.fill_sel  = sel_q;
  assign bus.fill_we   = rcv_en;
  assign bus.fill_word = rcv_idx;
  assign bus.fill_data = bus.mem_rdata;
  assign bus.fill_addr = base_q;
  assign bus.tag_we    = tag_we;

  assign bus.i_busy = bus.i_miss ||
    (state_q == FILL && sel_q == SEL_I);
  assign bus.d_busy = bus.d_miss ||
    (state_q == FILL && sel_q == SEL_D);

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: latency-4 memory model plus
// per-scenario tasks with a fill scoreboard queue.
module tb_cache_fill_ctrl;
  import cache_pkg::*;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } req_t;

  typedef struct {
    logic        sel;
    logic [15:0] base;
    logic [2:0]  word;
    logic [15:0] data;
    logic        tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   gap_after = 0;
  int   gap_len = 0;
  bit   spur = 1'b0;
  req_t req_q[$];
  exp_t exp_q[$];

  cache_fill_ctrl_if bus();

  cache_fill_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_val(
    input logic [15:0] a
  );
    return a ^ 16'h5A3C;
  endfunction

  function automatic void push_blk(
    input logic sel, input logic [15:0] base,
    input int n
  );
    for (int w = 0; w < n; w++) begin
      exp_t e;
      e.sel  = sel;
      e.base = base;
      e.word = 3'(w);
      e.data = mem_val(base + 16'(2 * w));
      e.tag  = (w == 7);
      exp_q.push_back(e);
    end
  endfunction

  // In-order memory: response MEM_LAT cycles after
  // the request, optionally stalled after N words.
  initial begin : mem_model
    int   resp_cnt;
    int   stall;
    req_t r;
    resp_cnt = 0;
    stall = 0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_en === 1'b1) begin
        r.addr = bus.mem_addr;
        r.due = cyc + MEM_LAT;
        req_q.push_back(r);
      end
      @(posedge clk);
      #1;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata = '0;
      if (stall > 0) begin
        stall--;
      end else if (req_q.size() > 0 &&
                   req_q[0].due <= cyc) begin
        r = req_q.pop_front();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = mem_val(r.addr);
        resp_cnt++;
        if (resp_cnt == gap_after) stall = gap_len;
        if (req_q.size() == 0) resp_cnt = 0;
      end else if (spur) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 16'hBEEF;
      end
    end
  end

  task automatic test_reset();
    logic [38:0] z;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      bus.i_miss = (k == 2);
      @(negedge clk);
      z = {bus.mem_en, bus.fill_we, bus.tag_we,
           bus.fill_sel, bus.fill_addr,
           bus.mem_addr, bus.fill_word};
      n_cmp++;
      if (z !== '0) begin
        n_bad++;
        $display("FAIL reset_outs k=%0d got %h exp 0",
                 k, z);
      end
      n_cmp++;
      if ({bus.i_busy, bus.d_busy} !== {k == 2, 1'b0})
      begin
        n_bad++;
        $display("FAIL reset_busy k=%0d got %b%b",
                 k, bus.i_busy, bus.d_busy);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.i_miss = 1'b0;
  endtask

  task automatic test_lone_i();
    exp_t e;
    logic [4:0] x;
    logic [15:0] ax;
    push_blk(SEL_I, 16'h1230, 8);
    for (int k = 0; k <= 13; k++) begin
      @(posedge clk);
      #1;
      bus.i_miss = (k <= 12);
      bus.i_miss_addr = 16'h1236;
      bus.d_miss = 1'b0;
      @(negedge clk);
      x = {k >= 1 && k <= 8, k == 12,
           k >= 5 && k <= 12, k <= 12, 1'b0};
      n_cmp++;
      if ({bus.mem_en, bus.tag_we, bus.fill_we,
           bus.i_busy, bus.d_busy} !== x) begin
        n_bad++;
        $display("FAIL lone_ctl k=%0d got %b%b%b%b%b exp %b",
                 k, bus.mem_en, bus.tag_we, bus.fill_we,
                 bus.i_busy, bus.d_busy, x);
      end
      ax = 16'h1230 + 16'(2 * (k - 1));
      if (x[4]) begin
        n_cmp++;
        if (bus.mem_addr !== ax) begin
          n_bad++;
          $display("FAIL lone_addr k=%0d got %h exp %h",
                   k, bus.mem_addr, ax);
        end
      end
      if (bus.fill_we === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL lone_fill k=%0d got extra exp none",
                   k);
        end else begin
          e = exp_q.pop_front();
          if ({bus.fill_sel, bus.fill_addr,
               bus.fill_word, bus.fill_data,
               bus.tag_we} !==
              {e.sel, e.base, e.word, e.data, e.tag})
          begin
            n_bad++;
            $display("FAIL lone_fill k=%0d got %h/%0d/%h exp %h/%0d/%h",
                     k, bus.fill_addr, bus.fill_word,
                     bus.fill_data, e.base, e.word, e.data);
          end
        end
      end
    end
  endtask

  task automatic test_dual();
    exp_t e;
    logic [4:0] x;
    logic [15:0] ax;
    push_blk(SEL_D, 16'h8000, 8);
    push_blk(SEL_I, 16'h0040, 8);
    for (int k = 0; k <= 26; k++) begin
      @(posedge clk);
      #1;
      bus.d_miss = (k <= 12);
      bus.d_miss_addr = 16'h8002;
      bus.i_miss = (k <= 25);
      bus.i_miss_addr = 16'h0040;
      @(negedge clk);
      x = {(k >= 1 && k <= 8) || (k >= 14 && k <= 21),
           k == 12 || k == 25,
           (k >= 5 && k <= 12) || (k >= 18 && k <= 25),
           k <= 25, k <= 12};
      n_cmp++;
      if ({bus.mem_en, bus.tag_we, bus.fill_we,
           bus.i_busy, bus.d_busy} !== x) begin
        n_bad++;
        $display("FAIL dual_ctl k=%0d got %b%b%b%b%b exp %b",
                 k, bus.mem_en, bus.tag_we, bus.fill_we,
                 bus.i_busy, bus.d_busy, x);
      end
      ax = (k <= 8) ? 16'h8000 + 16'(2 * (k - 1))
                    : 16'h0040 + 16'(2 * (k - 14));
      if (x[4]) begin
        n_cmp++;
        if (bus.mem_addr !== ax) begin
          n_bad++;
          $display("FAIL dual_addr k=%0d got %h exp %h",
                   k, bus.mem_addr, ax);
        end
      end
      if (bus.fill_we === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL dual_fill k=%0d got extra exp none",
                   k);
        end else begin
          e = exp_q.pop_front();
          if ({bus.fill_sel, bus.fill_addr,
               bus.fill_word, bus.fill_data,
               bus.tag_we} !==
              {e.sel, e.base, e.word, e.data, e.tag})
          begin
            n_bad++;
            $display("FAIL dual_fill k=%0d got %b/%h/%0d/%h exp %b/%h/%0d/%h",
                     k, bus.fill_sel, bus.fill_addr,
                     bus.fill_word, bus.fill_data,
                     e.sel, e.base, e.word, e.data);
          end
        end
      end
    end
  endtask

  task automatic test_gap();
    exp_t e;
    logic [4:0] x;
    gap_after = 4;
    gap_len = 3;
    push_blk(SEL_D, 16'h4A10, 8);
    for (int k = 0; k <= 16; k++) begin
      @(posedge clk);
      #1;
      bus.d_miss = (k <= 15);
      bus.d_miss_addr = 16'h4A1F;
      bus.i_miss = 1'b0;
      @(negedge clk);
      x = {k >= 1 && k <= 8, k == 15,
           (k >= 5 && k <= 8) || (k >= 12 && k <= 15),
           1'b0, k <= 15};
      n_cmp++;
      if ({bus.mem_en, bus.tag_we, bus.fill_we,
           bus.i_busy, bus.d_busy} !== x) begin
        n_bad++;
        $display("FAIL gap_ctl k=%0d got %b%b%b%b%b exp %b",
                 k, bus.mem_en, bus.tag_we, bus.fill_we,
                 bus.i_busy, bus.d_busy, x);
      end
      if (bus.fill_we === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL gap_fill k=%0d got extra exp none",
                   k);
        end else begin
          e = exp_q.pop_front();
          if ({bus.fill_sel, bus.fill_addr,
               bus.fill_word, bus.fill_data,
               bus.tag_we} !==
              {e.sel, e.base, e.word, e.data, e.tag})
          begin
            n_bad++;
            $display("FAIL gap_fill k=%0d got %0d/%h exp %0d/%h",
                     k, bus.fill_word, bus.fill_data,
                     e.word, e.data);
          end
        end
      end
    end
    gap_after = 0;
    gap_len = 0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [4:0] x;
    logic [15:0] ax;
    push_blk(SEL_I, 16'h2220, 2);
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk);
      #1;
      bus.i_miss = (k <= 5);
      bus.i_miss_addr = 16'h2222;
      bus.d_miss = 1'b0;
      rst = (k == 6);
      @(negedge clk);
      x = {k >= 1 && k <= 6, 1'b0,
           k == 5 || k == 6, k <= 6, 1'b0};
      n_cmp++;
      if ({bus.mem_en, bus.tag_we, bus.fill_we,
           bus.i_busy, bus.d_busy} !== x) begin
        n_bad++;
        $display("FAIL rstmid_ctl k=%0d got %b%b%b%b%b exp %b",
                 k, bus.mem_en, bus.tag_we, bus.fill_we,
                 bus.i_busy, bus.d_busy, x);
      end
      ax = 16'h2220 + 16'(2 * (k - 1));
      if (x[4]) begin
        n_cmp++;
        if (bus.mem_addr !== ax) begin
          n_bad++;
          $display("FAIL rstmid_addr k=%0d got %h exp %h",
                   k, bus.mem_addr, ax);
        end
      end
      if (bus.fill_we === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rstmid_fill k=%0d got extra exp none",
                   k);
        end else begin
          e = exp_q.pop_front();
          if ({bus.fill_addr, bus.fill_word,
               bus.fill_data} !==
              {e.base, e.word, e.data}) begin
            n_bad++;
            $display("FAIL rstmid_fill k=%0d got %0d/%h exp %0d/%h",
                     k, bus.fill_word, bus.fill_data,
                     e.word, e.data);
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL rstmid_left got %0d exp 0",
               exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_spurious();
    logic [4:0] x;
    spur = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      bus.i_miss = 1'b0;
      bus.d_miss = 1'b0;
      @(negedge clk);
      x = {bus.mem_en, bus.tag_we, bus.fill_we,
           bus.i_busy, bus.d_busy};
      n_cmp++;
      if (x !== 5'b0 || bus.mem_rvalid !== 1'b1) begin
        n_bad++;
        $display("FAIL spur_ctl k=%0d got %b rv %b exp 00000 rv 1",
                 k, x, bus.mem_rvalid);
      end
    end
    spur = 1'b0;
  endtask

  task automatic test_drop_miss();
    exp_t e;
    logic [4:0] x;
    push_blk(SEL_D, 16'h9AB0, 8);
    for (int k = 0; k <= 14; k++) begin
      @(posedge clk);
      #1;
      bus.d_miss = (k <= 2);
      bus.d_miss_addr = 16'h9ABC;
      bus.i_miss = 1'b0;
      @(negedge clk);
      x = {k >= 1 && k <= 8, k == 12,
           k >= 5 && k <= 12, 1'b0, k <= 12};
      n_cmp++;
      if ({bus.mem_en, bus.tag_we, bus.fill_we,
           bus.i_busy, bus.d_busy} !== x) begin
        n_bad++;
        $display("FAIL drop_ctl k=%0d got %b%b%b%b%b exp %b",
                 k, bus.mem_en, bus.tag_we, bus.fill_we,
                 bus.i_busy, bus.d_busy, x);
      end
      if (bus.fill_we === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL drop_fill k=%0d got extra exp none",
                   k);
        end else begin
          e = exp_q.pop_front();
          if ({bus.fill_sel, bus.fill_addr,
               bus.fill_word, bus.fill_data,
               bus.tag_we} !==
              {e.sel, e.base, e.word, e.data, e.tag})
          begin
            n_bad++;
            $display("FAIL drop_fill k=%0d got %h/%0d/%h exp %h/%0d/%h",
                     k, bus.fill_addr, bus.fill_word,
                     bus.fill_data, e.base, e.word, e.data);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.i_miss = 1'b0;
    bus.i_miss_addr = '0;
    bus.d_miss = 1'b0;
    bus.d_miss_addr = '0;
    test_reset();
    test_lone_i();
    test_dual();
    test_gap();
    test_reset_mid();
    test_spurious();
    test_drop_miss();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d exp 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Miss-handling controller shared by the instruction and data caches of the pipelined CPU. On a cache miss it arbitrates between the two caches, issues eight pipelined word reads to multi-cycle main memory, and streams the returned words into the requesting cache's data array. On the last word it writes the tag/valid entry. It drives per-cache busy lines that stall the fetch and memory stages until the block is resident.

## Interface
Parameters:
- ADDR_W, 16, byte address width
- BLK_WORDS, 8, 16-bit words per cache block (16-byte block)
- MEM_LAT, 4, cycles from mem_en to matching mem_rvalid

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- i_miss  in  1  icache lookup missed this cycle
- i_miss_addr  in  16  icache miss byte address
- d_miss  in  1  dcache lookup missed this cycle
- d_miss_addr  in  16  dcache miss byte address
- i_busy  out  1  icache miss pending or being serviced
- d_busy  out  1  dcache miss pending or being serviced
- mem_en  out  1  main-memory read request strobe, one word per cycle
- mem_addr  out  16  word address of current request
- mem_rdata  in  16  returned read data
- mem_rvalid  in  1  mem_rdata valid; responses arrive in request order
- fill_sel  out  1  0 = icache, 1 = dcache target of fill
- fill_we  out  1  write one word into the selected data array
- fill_word  out  3  word index within block for fill_we
- fill_data  out  16  word to write (equals mem_rdata)
- fill_addr  out  16  block base address being filled ({addr[15:4], 4'h0})
- tag_we  out  1  write tag/valid for fill_addr into the selected tag array

## Operation
- States: IDLE, FILL.
- IDLE: if d_miss, grant D; else if i_miss, grant I. The winner's address is latched as {addr[15:4],4'h0}, fill_sel is set, both counters are cleared, and the FSM goes to FILL. With no miss, the FSM stays in IDLE.
- Simultaneous i_miss and d_miss: D wins. I is served in the IDLE cycle following D's completion, provided i_miss is still high.
- FILL issue side: mem_en=1 while issue_cnt<8. mem_addr = {base[15:4], issue_cnt, 1'b0}. issue_cnt increments per issued request and saturates at 8.
- FILL receive side: each mem_rvalid with recv_cnt<8 gives fill_we=1, fill_word=recv_cnt, fill_data=mem_rdata, and recv_cnt increments.
- On the rvalid with recv_cnt==7, tag_we=1 in the same cycle and the next state is IDLE.
- mem_rvalid in IDLE, or after 8 words have been received, is ignored: no writes, no counter change.
- x_busy = x_miss | (state==FILL & fill_sel==x). Busy is combinational and high in the same cycle the miss appears.
- A miss deasserting mid-fill does not abort the fill; the block completes.
- fill_sel and fill_addr hold their values throughout FILL.
- rst in any state: next cycle is IDLE, counters are 0, and there are no further fill_we/tag_we. In-flight memory responses are then ignored.
- Reset values: state IDLE; mem_en, fill_we, tag_we = 0; fill_sel = 0; fill_addr = 0; mem_addr = 0; fill_word = 0; i_busy and d_busy follow the miss inputs only.

## Timing
- Cycle 0 is an IDLE cycle with the miss high.
- Cycle 1 is the first FILL cycle. mem_en is high in cycles 1–8.
- With MEM_LAT=4, mem_rvalid arrives in cycles 5–12, giving fill_we in cycles 5–12. tag_we is in cycle 12.
- Cycle 13 is IDLE. busy drops in cycle 13 if the cache now hits.
- Total miss penalty: 13 cycles for BLK_WORDS=8 and MEM_LAT=4 (BLK_WORDS+MEM_LAT+1).
- Back-to-back misses: the second fill's mem_en starts no earlier than one cycle after the first fill's tag_we.
- Gaps in mem_rvalid only extend FILL; no timeout.

## Structure
- Shared package cache_pkg holds:
  - BLK_WORDS, WORD_IDX_W (=3), ADDR_W
  - the fill_state_t enum {IDLE, FILL}
  - the req_sel_t enum {SEL_I=0, SEL_D=1}
- One sub-module, blk_word_cnt: a clear/enable counter of width WORD_IDX_W+1 with a done flag at BLK_WORDS. It is instantiated twice, for issue_cnt and recv_cnt.

## Test plan
- Lone i_miss, addr 0x1236, MEM_LAT=4 → mem_addr 0x1230..0x123E in cycles 1–8; fill_word 0..7 in cycles 5–12; tag_we in cycle 12 with fill_addr 0x1230 and fill_sel 0; i_busy high cycles 0–12.
- i_miss 0x0040 and d_miss 0x8002 in the same cycle → D filled first (fill_sel=1, base 0x8000); I fill starts in cycle 13 with base 0x0040; i_busy high throughout.
- Memory model inserts a 3-cycle rvalid gap after the 4th word → fill_word stays sequential 0..7, tag_we moves 3 cycles later, no extra mem_en.
- rst asserted in cycle 6 of a fill → cycle 7 is IDLE with fill_we/tag_we low; the remaining rvalids ignored; a new miss afterwards fills correctly from word 0.
- Spurious mem_rvalid in IDLE with data 0xBEEF → no fill_we, no tag_we, counters unchanged.
- d_miss dropped after cycle 2 → fill still completes all 8 words and tag_we; d_busy low from cycle 13.
